pwm_apb_arbiter: RTL and testbench

PWM_APB_ARBITER -- requirements
Module: pwm_apb_arbiter

---
 rtl/pwm_apb_pkg.sv | 19 +
 rtl/pwm_rr_arb2.sv | 23 ++
 rtl/pwm_apb_arbiter.sv | 134 +++++++++++++
 tb/tb_pwm_apb_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_apb_pkg.sv
// Shared state encoding and bus sizes for the two-requester APB master toward pwm_controller.
package pwm_apb_pkg;

   localparam int APB_AW = 12;
   localparam int APB_DW = 32;
   localparam int NREQ   = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } apb_state_e;

   function automatic logic [NREQ-1:0] onehot_gnt(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/pwm_rr_arb2.sv
// Combinational 2-way round-robin grant; zero latency, no backpressure of its own.
module pwm_rr_arb2
   import pwm_apb_pkg::*;
(
   input  logic [NREQ-1:0] req_i,
   input  logic            last_gnt_i,
   output logic            gnt_vld_o,
   output logic            gnt_idx_o
);

   always_comb begin
      gnt_vld_o = |req_i;
      gnt_idx_o = 1'b0;
      case (req_i)
         2'b01:   gnt_idx_o = 1'b0;
         2'b10:   gnt_idx_o = 1'b1;
         // on contention the requester that did not win last time goes first
         2'b11:   gnt_idx_o = ~last_gnt_i;
         default: gnt_idx_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/pwm_apb_arbiter.sv
// Two-requester APB master: round-robin grant, one APB transfer per grant, optional ACCESS timeout.
// Latency req->done is 3 cycles with a zero-wait slave; pready_i low stretches ACCESS, requests sampled only in IDLE.
module pwm_apb_arbiter
   import pwm_apb_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic                   pclk_i,
   input  logic                   preset_i,
   input  logic [NREQ-1:0]        req_i,
   input  logic [NREQ-1:0]        we_i,
   input  logic [NREQ*APB_AW-1:0] addr_i,
   input  logic [NREQ*APB_DW-1:0] wdata_i,
   output logic [NREQ-1:0]        done_o,
   output logic [APB_DW-1:0]      rdata_o,
   output logic                   err_o,
   output logic                   busy_o,
   output logic                   psel_o,
   output logic                   penable_o,
   output logic                   pwrite_o,
   output logic [APB_AW-1:0]      paddr_o,
   output logic [APB_DW-1:0]      pwdata_o,
   input  logic [APB_DW-1:0]      prdata_i,
   input  logic                   pready_i,
   input  logic                   pslverr_i
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX  = '1;
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   apb_state_e        state_q;
   logic              last_gnt_q;
   logic              gnt_q;
   logic [CW-1:0]     cnt_q;
   logic              psel_q;
   logic              penable_q;
   logic              pwrite_q;
   logic              err_q;
   logic              busy_q;
   logic [APB_AW-1:0] paddr_q;
   logic [APB_DW-1:0] pwdata_q;
   logic [APB_DW-1:0] rdata_q;
   logic [NREQ-1:0]   done_q;

   logic              gnt_vld_d;
   logic              gnt_idx_d;
   logic              sel_we_d;
   logic              timeout_d;
   logic [APB_AW-1:0] sel_addr_d;
   logic [APB_DW-1:0] sel_wdata_d;

   pwm_rr_arb2 u_arb (
      .req_i      (req_i),
      .last_gnt_i (last_gnt_q),
      .gnt_vld_o  (gnt_vld_d),
      .gnt_idx_o  (gnt_idx_d)
   );

   always_comb begin
      sel_we_d    = gnt_idx_d ? we_i[1] : we_i[0];
      sel_addr_d  = gnt_idx_d ? addr_i[2*APB_AW-1:APB_AW] : addr_i[APB_AW-1:0];
      sel_wdata_d = gnt_idx_d ? wdata_i[2*APB_DW-1:APB_DW] : wdata_i[APB_DW-1:0];
      // cnt_q holds the number of already-elapsed low-pready ACCESS cycles
      timeout_d   = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
   end

   always_ff @(posedge pclk_i) begin
      if (preset_i) begin
         state_q    <= IDLE;
         last_gnt_q <= 1'b1;
         gnt_q      <= 1'b0;
         cnt_q      <= '0;
         psel_q     <= 1'b0;
         penable_q  <= 1'b0;
         pwrite_q   <= 1'b0;
         paddr_q    <= '0;
         pwdata_q   <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         done_q     <= '0;
         busy_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (gnt_vld_d) begin
                  state_q    <= SETUP;
                  gnt_q      <= gnt_idx_d;
                  last_gnt_q <= gnt_idx_d;
                  pwrite_q   <= sel_we_d;
                  paddr_q    <= sel_addr_d;
                  pwdata_q   <= sel_wdata_d;
                  cnt_q      <= '0;
                  psel_q     <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            SETUP: begin
               state_q   <= ACCESS;
               penable_q <= 1'b1;
            end
            ACCESS: begin
               if (pready_i || timeout_d) begin
                  state_q   <= DONE;
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
                  done_q    <= onehot_gnt(gnt_q);
                  rdata_q   <= (pready_i && !pwrite_q) ? prdata_i : '0;
                  err_q     <= pready_i ? pslverr_i : 1'b1;
               end else if (cnt_q != CNT_MAX) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= '0;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign done_o    = done_q;
   assign rdata_o   = rdata_q;
   assign err_o     = err_q;
   assign busy_o    = busy_q;
   assign psel_o    = psel_q;
   assign penable_o = penable_q;
   assign pwrite_o  = pwrite_q;
   assign paddr_o   = paddr_q;
   assign pwdata_o  = pwdata_q;

endmodule

// File: tb/tb_pwm_apb_arbiter.sv
// Bench for pwm_apb_arbiter: directed scenarios plus randomized transactions against a reference model.
module tb_pwm_apb_arbiter;

   logic        pclk_i;
   logic        preset_i;
   logic [1:0]  req_i;
   logic [1:0]  we_i;
   logic [23:0] addr_i;
   logic [63:0] wdata_i;
   logic [31:0] prdata_i;
   logic        pready_i;
   logic        pslverr_i;

   logic [1:0]  done_o;
   logic [31:0] rdata_o;
   logic        err_o, busy_o, psel_o, penable_o, pwrite_o;
   logic [11:0] paddr_o;
   logic [31:0] pwdata_o;

   logic [1:0]  done0;
   logic [31:0] rdata0;
   logic        err0, busy0, psel0, penable0, pwrite0;
   logic [11:0] paddr0;
   logic [31:0] pwdata0;

   pwm_apb_arbiter #(.TIMEOUT(16)) dut (
      .pclk_i(pclk_i), .preset_i(preset_i), .req_i(req_i), .we_i(we_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .done_o(done_o), .rdata_o(rdata_o),
      .err_o(err_o), .busy_o(busy_o), .psel_o(psel_o), .penable_o(penable_o),
      .pwrite_o(pwrite_o), .paddr_o(paddr_o), .pwdata_o(pwdata_o),
      .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
   );

   pwm_apb_arbiter #(.TIMEOUT(0)) dut_nt (
      .pclk_i(pclk_i), .preset_i(preset_i), .req_i(req_i), .we_i(we_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .done_o(done0), .rdata_o(rdata0),
      .err_o(err0), .busy_o(busy0), .psel_o(psel0), .penable_o(penable0),
      .pwrite_o(pwrite0), .paddr_o(paddr0), .pwdata_o(pwdata0),
      .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
   );

   initial pclk_i = 1'b0;
   always #5 pclk_i = ~pclk_i;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_last;

   int          o_sel, o_en, o_done, o_acc;
   logic [1:0]  o_done_v;
   logic [31:0] o_rdata;
   logic        o_err;
   logic [11:0] o_paddr;
   logic        o_pwrite;
   logic [31:0] o_pwdata;
   bit          o_stable;
   logic [1:0]  p_done;
   logic [31:0] p_rdata;
   logic        p_busy;

   // reference rules: single request wins, contention goes to the one that did not win last
   function automatic int ref_winner(input logic [1:0] mask, input int last);
      if (mask == 2'b01) return 0;
      if (mask == 2'b10) return 1;
      return 1 - last;
   endfunction

   function automatic int ref_access_cycles(input int waits, input int tmo);
      if (tmo != 0 && waits >= tmo) return tmo;
      return waits + 1;
   endfunction

   task automatic apply_reset();
      preset_i = 1'b1; req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0;
      prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;
      repeat (2) @(negedge pclk_i);
      preset_i = 1'b0;
      exp_last = 1;
   endtask

   // drives one request from IDLE and records what the DUT did; cycles counted from the request negedge
   task automatic run_txn(input logic [1:0] mask, input logic [1:0] we, input logic [23:0] addr,
                          input logic [63:0] wdata, input int waits, input logic [31:0] prd,
                          input logic slverr, input bit scramble);
      int cyc;
      int acc;
      o_sel = -1; o_en = -1; o_done = -1; o_stable = 1'b1; acc = 0; cyc = 0;
      o_done_v = 'x; o_rdata = 'x; o_err = 'x; o_paddr = 'x; o_pwrite = 'x; o_pwdata = 'x;
      req_i = mask; we_i = we; addr_i = addr; wdata_i = wdata;
      prdata_i = prd; pslverr_i = slverr; pready_i = 1'b0;
      while (o_done < 0 && cyc < 60) begin
         @(negedge pclk_i);
         cyc++;
         if (psel_o && !penable_o && o_sel < 0) begin
            o_sel = cyc; o_paddr = paddr_o; o_pwrite = pwrite_o; o_pwdata = pwdata_o;
            if (scramble) begin
               we_i = 2'($urandom); addr_i = 24'($urandom); wdata_i = {$urandom, $urandom};
            end
         end
         if (penable_o) begin
            if (o_en < 0) o_en = cyc;
            acc++;
            if (paddr_o !== o_paddr || pwrite_o !== o_pwrite || pwdata_o !== o_pwdata) o_stable = 1'b0;
            pready_i = (acc > waits);
         end
         if (done_o !== 2'b00) begin
            o_done = cyc; o_done_v = done_o; o_rdata = rdata_o; o_err = err_o;
         end
      end
      o_acc = acc;
      req_i = '0; pready_i = 1'b0;
      @(negedge pclk_i);
      p_done = done_o; p_rdata = rdata_o; p_busy = busy_o;
   endtask

   task automatic test_reset();
      apply_reset();
      n_cmp++;
      if ({done_o, rdata_o, err_o, busy_o, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o} !== '0) begin
         n_bad++; $display("FAIL reset_outputs: got %h required 0",
            {done_o, rdata_o, err_o, busy_o, psel_o, penable_o, pwrite_o, paddr_o, pwdata_o});
      end
      n_cmp++;
      if ({done0, rdata0, err0, busy0, psel0, penable0, pwrite0, paddr0, pwdata0} !== '0) begin
         n_bad++; $display("FAIL reset_outputs_nt: got %h required 0",
            {done0, rdata0, err0, busy0, psel0, penable0, pwrite0, paddr0, pwdata0});
      end
      run_txn(2'b10, 2'b00, 24'h5A5_000, 64'h1111_2222_0000_0000, 0, 32'hCAFE_F00D, 1'b1, 1'b0);
      apply_reset();
      n_cmp++;
      if ({rdata_o, err_o, paddr_o, pwdata_o, busy_o} !== '0) begin
         n_bad++; $display("FAIL reset_after_txn: got %h required 0", {rdata_o, err_o, paddr_o, pwdata_o, busy_o});
      end
   endtask

   task automatic test_single_write();
      apply_reset();
      run_txn(2'b01, 2'b01, 24'h000_010, 64'h0000_0000_0000_00FF, 0, 32'h1234_5678, 1'b0, 1'b0);
      n_cmp++; if (o_sel !== 1) begin n_bad++; $display("FAIL write_psel_cycle: got %0d required 1", o_sel); end
      n_cmp++; if (o_en !== 2) begin n_bad++; $display("FAIL write_penable_cycle: got %0d required 2", o_en); end
      n_cmp++; if (o_done !== 3) begin n_bad++; $display("FAIL write_done_cycle: got %0d required 3", o_done); end
      n_cmp++; if (o_done_v !== 2'b01) begin n_bad++; $display("FAIL write_done_vec: got %b required 01", o_done_v); end
      n_cmp++; if (o_err !== 1'b0) begin n_bad++; $display("FAIL write_err: got %b required 0", o_err); end
      n_cmp++;
      if ({o_paddr, o_pwrite, o_pwdata} !== {12'h010, 1'b1, 32'h0000_00FF}) begin
         n_bad++; $display("FAIL write_apb_fields: got %h/%b/%h required 010/1/000000ff", o_paddr, o_pwrite, o_pwdata);
      end
      n_cmp++; if (o_rdata !== 32'h0) begin n_bad++; $display("FAIL write_rdata: got %h required 0", o_rdata); end
   endtask

   task automatic test_contention();
      int w;
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         w = ref_winner(2'b11, exp_last);
         exp_last = w;
         run_txn(2'b11, 2'b00, {12'hB0B, 12'hA0A}, 64'h0, 0, 32'h0C0D_E000 + 32'(i), 1'b0, 1'b0);
         n_cmp++;
         if (o_done_v !== ((w == 1) ? 2'b10 : 2'b01)) begin
            n_bad++; $display("FAIL contention_order[%0d]: got %b required requester %0d", i, o_done_v, w);
         end
         n_cmp++;
         if (o_paddr !== ((w == 1) ? 12'hB0B : 12'hA0A)) begin
            n_bad++; $display("FAIL contention_addr[%0d]: got %h required requester %0d address", i, o_paddr, w);
         end
      end
   endtask

   task automatic test_wait_states();
      apply_reset();
      run_txn(2'b10, 2'b00, {12'h3C4, 12'h000}, 64'h0, 3, 32'hDEAD_BEEF, 1'b0, 1'b0);
      n_cmp++; if (o_done !== 6) begin n_bad++; $display("FAIL wait_done_cycle: got %0d required 6", o_done); end
      n_cmp++; if (o_acc !== 4) begin n_bad++; $display("FAIL wait_access_cycles: got %0d required 4", o_acc); end
      n_cmp++; if (o_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wait_rdata: got %h required deadbeef", o_rdata); end
      n_cmp++; if (o_done_v !== 2'b10) begin n_bad++; $display("FAIL wait_done_vec: got %b required 10", o_done_v); end
      n_cmp++;
      if (!o_stable || o_paddr !== 12'h3C4) begin
         n_bad++; $display("FAIL wait_paddr_stable: got %h stable=%0d required 3c4 stable=1", o_paddr, o_stable);
      end
      n_cmp++; if (p_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wait_rdata_hold: got %h required deadbeef", p_rdata); end
   endtask

   task automatic test_timeout();
      apply_reset();
      run_txn(2'b01, 2'b00, 24'h000_777, 64'h0, 1000, 32'hFFFF_FFFF, 1'b0, 1'b0);
      n_cmp++; if (o_acc !== 16) begin n_bad++; $display("FAIL timeout_access_cycles: got %0d required 16", o_acc); end
      n_cmp++; if (o_done !== 18) begin n_bad++; $display("FAIL timeout_done_cycle: got %0d required 18", o_done); end
      n_cmp++;
      if ({o_done_v, o_err, o_rdata} !== {2'b01, 1'b1, 32'h0}) begin
         n_bad++; $display("FAIL timeout_result: got done=%b err=%b rdata=%h required 01/1/0", o_done_v, o_err, o_rdata);
      end
      n_cmp++;
      if ({p_done, p_busy} !== 3'b000) begin
         n_bad++; $display("FAIL timeout_after: got done=%b busy=%b required 00/0", p_done, p_busy);
      end
   endtask

   task automatic test_timeout_disabled();
      bit seen_done;
      bit seen_idle;
      int k;
      apply_reset();
      req_i = 2'b01; we_i = 2'b00; addr_i = 24'h000_321; prdata_i = 32'h5A5A_0001;
      pready_i = 1'b0; pslverr_i = 1'b0;
      seen_done = 1'b0; seen_idle = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge pclk_i);
         if (done0 !== 2'b00) seen_done = 1'b1;
         if (i >= 2 && busy0 !== 1'b1) seen_idle = 1'b1;
      end
      n_cmp++;
      if (seen_done || seen_idle || penable0 !== 1'b1) begin
         n_bad++; $display("FAIL notimeout_waits: got done=%0d idle=%0d penable=%b required 0/0/1", seen_done, seen_idle, penable0);
      end
      pready_i = 1'b1;
      k = 0;
      while (done0 === 2'b00 && k < 4) begin
         @(negedge pclk_i);
         k++;
      end
      n_cmp++;
      if ({done0, err0, rdata0} !== {2'b01, 1'b0, 32'h5A5A_0001}) begin
         n_bad++; $display("FAIL notimeout_complete: got done=%b err=%b rdata=%h required 01/0/5a5a0001", done0, err0, rdata0);
      end
      req_i = '0; pready_i = 1'b0;
   endtask

   task automatic test_slverr();
      apply_reset();
      run_txn(2'b01, 2'b01, 24'h000_044, 64'h0000_0000_0000_0033, 0, 32'h0, 1'b1, 1'b0);
      n_cmp++;
      if ({o_done_v, o_err} !== {2'b01, 1'b1}) begin
         n_bad++; $display("FAIL slverr_write: got done=%b err=%b required 01/1", o_done_v, o_err);
      end
      run_txn(2'b10, 2'b00, {12'h055, 12'h0}, 64'h0, 2, 32'h0BAD_0BAD, 1'b1, 1'b0);
      n_cmp++;
      if ({o_done_v, o_err, o_rdata} !== {2'b10, 1'b1, 32'h0BAD_0BAD}) begin
         n_bad++; $display("FAIL slverr_read: got done=%b err=%b rdata=%h required 10/1/0bad0bad", o_done_v, o_err, o_rdata);
      end
      n_cmp++; if (p_done !== 2'b00) begin n_bad++; $display("FAIL slverr_one_pulse: got %b required 00", p_done); end
   endtask

   task automatic test_reset_access();
      bit seen_done;
      int k;
      apply_reset();
      req_i = 2'b01; we_i = 2'b00; addr_i = 24'h000_ABC; pready_i = 1'b0;
      k = 0;
      while (penable_o !== 1'b1 && k < 6) begin
         @(negedge pclk_i);
         k++;
      end
      repeat (2) @(negedge pclk_i);
      preset_i = 1'b1;
      @(negedge pclk_i);
      preset_i = 1'b0; req_i = '0;
      exp_last = 1;
      n_cmp++;
      if ({psel_o, penable_o, busy_o, done_o} !== 5'b0) begin
         n_bad++; $display("FAIL reset_in_access: got psel=%b pen=%b busy=%b done=%b required all 0", psel_o, penable_o, busy_o, done_o);
      end
      seen_done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge pclk_i);
         if (done_o !== 2'b00 || psel_o !== 1'b0) seen_done = 1'b1;
      end
      n_cmp++; if (seen_done) begin n_bad++; $display("FAIL reset_no_done: got activity=1 required 0"); end
      run_txn(2'b11, 2'b00, 24'h0, 64'h0, 0, 32'h0, 1'b0, 1'b0);
      n_cmp++;
      if (o_done_v !== ((ref_winner(2'b11, exp_last) == 1) ? 2'b10 : 2'b01)) begin
         n_bad++; $display("FAIL reset_then_contention: got %b required 01", o_done_v);
      end
   endtask

   task automatic test_random();
      logic [1:0]  mask, we;
      logic [23:0] addr;
      logic [63:0] wdata;
      logic [31:0] prd, exp_rdata;
      logic        slverr, exp_err;
      int          w, waits, exp_acc;
      bit          to;
      apply_reset();
      for (int i = 0; i < 40; i++) begin
         mask   = 2'($urandom_range(1, 3));
         we     = 2'($urandom);
         addr   = 24'($urandom);
         wdata  = {$urandom, $urandom};
         prd    = $urandom;
         slverr = ($urandom_range(0, 3) == 0);
         waits  = int'($urandom_range(0, 20));
         w = ref_winner(mask, exp_last);
         exp_last = w;
         exp_acc = ref_access_cycles(waits, 16);
         to = (waits >= 16);
         exp_rdata = (to || we[w]) ? 32'h0 : prd;
         exp_err = to ? 1'b1 : slverr;
         run_txn(mask, we, addr, wdata, waits, prd, slverr, 1'b1);
         n_cmp++;
         if (o_done !== 2 + exp_acc || o_sel !== 1 || o_en !== 2) begin
            n_bad++; $display("FAIL rand_timing[%0d]: got sel=%0d en=%0d done=%0d required 1/2/%0d", i, o_sel, o_en, o_done, 2 + exp_acc);
         end
         n_cmp++;
         if (o_done_v !== ((w == 1) ? 2'b10 : 2'b01)) begin
            n_bad++; $display("FAIL rand_grant[%0d]: got %b required requester %0d", i, o_done_v, w);
         end
         n_cmp++;
         if ({o_paddr, o_pwrite, o_pwdata} !== {addr[w*12 +: 12], we[w], wdata[w*32 +: 32]} || !o_stable) begin
            n_bad++; $display("FAIL rand_apb[%0d]: got %h/%b/%h stable=%0d required %h/%b/%h", i,
               o_paddr, o_pwrite, o_pwdata, o_stable, addr[w*12 +: 12], we[w], wdata[w*32 +: 32]);
         end
         n_cmp++;
         if ({o_rdata, o_err} !== {exp_rdata, exp_err}) begin
            n_bad++; $display("FAIL rand_result[%0d]: got %h/%b required %h/%b", i, o_rdata, o_err, exp_rdata, exp_err);
         end
         n_cmp++;
         if ({p_done, p_busy} !== 3'b000 || p_rdata !== exp_rdata) begin
            n_bad++; $display("FAIL rand_after[%0d]: got done=%b busy=%b rdata=%h required 00/0/%h", i, p_done, p_busy, p_rdata, exp_rdata);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_contention();
      test_wait_states();
      test_timeout();
      test_timeout_disabled();
      test_slverr();
      test_reset_access();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
